// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the programmable sequence detector.
// Holds the FSM state encoding and the length-field width calculation.
package seq_det_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        MATCH = 1'b1
    } det_state_e;

    // Width needed to hold a length value in 0..max_len inclusive.
    function automatic int len_w_of(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register with a saturating fill counter.
// Clear wins over shift so a reload or a non-overlap restart is clean.
module seq_det_hist import seq_det_pkg::*; #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_w_of(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               clear,
    input  logic               din,
    output logic [MAX_LEN-1:0] hist,
    output logic [LEN_W-1:0]   fill
);

    logic [MAX_LEN-1:0] hist_d, hist_q;
    logic [LEN_W-1:0]   fill_d, fill_q;

    // Next history/fill: clear, else shift in and count up to MAX_LEN.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hist_d = {hist_q[MAX_LEN-2:0], din};
            if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with overlap control,
// runtime reconfiguration and a saturating match counter.
module seq_det_prog import seq_det_pkg::*; #(
    parameter int                MAX_LEN     = 8,
    parameter int                CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1001),
    parameter int                DEF_LEN     = 4,
    parameter bit                DEF_OVL     = 1'b1,
    localparam int               LEN_W       = len_w_of(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signal,
    input  logic               valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pattern_d, pattern_q;
    logic [LEN_W-1:0]   len_d, len_q;
    logic               ovl_d, ovl_q;
    det_state_e         state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               cfg_err_d, cfg_err_q;

    logic [MAX_LEN-1:0] hist, hist_upd, mask;
    logic [LEN_W-1:0]   fill, fill_upd;
    logic               cfg_ok, load, shift, clear, hit;

    seq_det_hist #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .shift (shift),
        .clear (clear),
        .din   (signal),
        .hist  (hist),
        .fill  (fill)
    );

    // Match detection on post-shift history, config and counter updates.
    always_comb begin
        cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        load     = cfg_load && cfg_ok;
        hist_upd = {hist[MAX_LEN-2:0], signal};
        fill_upd = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        hit   = valid && !load
              && ((hist_upd & mask) == (pattern_q & mask))
              && (fill_upd >= len_q);
        shift = valid && !load;
        // Without overlap the next match must be built from fresh bits.
        clear = load || (hit && !ovl_q);

        pattern_d = pattern_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        if (load) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            ovl_d     = cfg_ovl;
        end
        cfg_err_d = cfg_load && !cfg_ok;
        state_d   = hit ? MATCH : HUNT;

        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FSM state, configuration, counter and error pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= DEF_OVL;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign out       = (state_q == MATCH);
    assign match_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule
